// File: rtl/serial_word_receiver.sv
// serial_word_receiver: reassembles WIDTH-bit words from a one-bit-per-strobe
// serial line (MSB-first or LSB-first, chosen per word) and presents them on a
// valid/ready port. A word that completes while an unconsumed word is still
// held is dropped and raises a sticky overrun flag.
module serial_word_receiver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_lat_q, dir_lat_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;

  logic               dir_eff;
  logic [WIDTH-1:0]   shifted;
  logic               last_bit;

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      dir_lat_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      dir_lat_q <= dir_lat_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  // Next-state: shifting, word completion, output handshake, clear and overrun.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    dir_lat_d = dir_lat_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;

    // The first bit of a word uses the live dir; later bits use the latched one.
    dir_eff  = (state_q == IDLE) ? dir : dir_lat_q;
    shifted  = dir_eff ? {shreg_q[WIDTH-2:0], sin} : {sin, shreg_q[WIDTH-1:1]};
    last_bit = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (clr) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (sin_valid) begin
      shreg_d = shifted;
      if (state_q == IDLE) begin
        dir_lat_d = dir;
      end
      if (last_bit) begin
        state_d = IDLE;
        cnt_d   = '0;
        // A held word only makes room if it is consumed on this same edge.
        if (!valid_q || out_ready) begin
          data_d  = shifted;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        state_d = SHIFT;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign bit_cnt   = cnt_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver: directed scenarios plus randomized traffic, all
// checked against a bit-list reference model of the serial receiver.
module tb_serial_word_receiver;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
  localparam int VW    = WIDTH + CNT_W + 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sin = 1'b0;
  logic             sin_valid = 1'b0;
  logic             dir = 1'b0;
  logic             clr = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             overrun;
  logic [CNT_W-1:0] bit_cnt;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: list of bits received so far in the current word.
  int               m_n;
  logic             m_bits [WIDTH];
  logic             m_dir;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ovr;

  serial_word_receiver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .dir(dir),
    .clr(clr), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .bit_cnt(bit_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] exp_vec();
    return {m_data, m_valid, m_ovr, CNT_W'(m_n), (m_n != 0)};
  endfunction

  task automatic model_reset();
    m_n = 0; m_dir = 1'b0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
    for (int i = 0; i < WIDTH; i++) m_bits[i] = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic s, input logic d,
                            input logic c, input logic r);
    logic             was_valid;
    logic [WIDTH-1:0] word;
    was_valid = m_valid;
    if (m_valid && r) m_valid = 1'b0;
    if (c) begin
      m_n = 0; m_ovr = 1'b0;
    end else if (v) begin
      if (m_n == 0) m_dir = d;
      m_bits[m_n] = s;
      m_n++;
      if (m_n == WIDTH) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (m_dir) word[WIDTH-1-i] = m_bits[i];
          else       word[i]         = m_bits[i];
        end
        m_n = 0;
        if (!was_valid || r) begin
          m_data = word; m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance model on the edge, settle 1 time unit.
  task automatic cyc(input logic v, input logic s, input logic d,
                     input logic c, input logic r);
    sin_valid = v; sin = s; dir = d; clr = c; out_ready = r;
    @(posedge clk);
    model_edge(v, s, d, c, r);
    #1;
    sin_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] bits_in_order, input logic d,
                           input logic r_last);
    for (int i = 0; i < WIDTH; i++)
      cyc(1'b1, bits_in_order[WIDTH-1-i], d, 1'b0, (i == WIDTH-1) ? r_last : 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    model_reset();
    n_cmp++;
    if ({data_out, out_valid, overrun, bit_cnt, busy} !== '0) begin
      n_err++; $display("FAIL reset: got %b want %b", {data_out, out_valid, overrun, bit_cnt, busy}, {VW{1'b0}});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_msb_first();
    logic [3:0] b;
    logic [CNT_W-1:0] cnt_exp [4];
    b = 4'b1011;
    cnt_exp[0] = 1; cnt_exp[1] = 2; cnt_exp[2] = 3; cnt_exp[3] = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, b[3-i], 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (bit_cnt !== cnt_exp[i] || busy !== (i != 3)) begin
        n_err++; $display("FAIL msb_cnt[%0d]: got cnt=%0d busy=%b want cnt=%0d busy=%b", i, bit_cnt, busy, cnt_exp[i], (i != 3));
      end
    end
    n_cmp++;
    if (data_out !== 4'b1011 || out_valid !== 1'b1 || exp_vec() !== {data_out, out_valid, overrun, bit_cnt, busy}) begin
      n_err++; $display("FAIL msb_word: got data=%b valid=%b want data=1011 valid=1", data_out, out_valid);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_lsb_first();
    send_word(4'b1011, 1'b0, 1'b0);
    n_cmp++;
    if (data_out !== 4'b1101 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL lsb_word: got data=%b valid=%b want data=1101 valid=1", data_out, out_valid);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (data_out !== 4'b1101 || exp_vec() !== {data_out, out_valid, overrun, bit_cnt, busy}) begin
      n_err++; $display("FAIL lsb_dir_latch: got data=%b want data=1101", data_out);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    send_word(4'b1011, 1'b1, 1'b0);
    send_word(4'b0110, 1'b1, 1'b0);
    n_cmp++;
    if (data_out !== 4'b1011 || out_valid !== 1'b1 || overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_drop: got data=%b valid=%b ovr=%b want 1011 1 1", data_out, out_valid, overrun);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || overrun !== 1'b1 || data_out !== 4'b1011) begin
      n_err++; $display("FAIL overrun_sticky: got valid=%b ovr=%b data=%b want 0 1 1011", out_valid, overrun, data_out);
    end
  endtask

  task automatic test_clr();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (bit_cnt !== '0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL clr_abort: got cnt=%0d busy=%b ovr=%b want 0 0 0", bit_cnt, busy, overrun);
    end
    send_word(4'b0011, 1'b1, 1'b0);
    n_cmp++;
    if (data_out !== 4'b0011 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      n_err++; $display("FAIL clr_next_word: got data=%b valid=%b ovr=%b want 0011 1 0", data_out, out_valid, overrun);
    end
  endtask

  task automatic test_back_to_back();
    // Word 0011 from the previous test is still pending.
    send_word(4'b0101, 1'b1, 1'b1);
    n_cmp++;
    if (data_out !== 4'b0101 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      n_err++; $display("FAIL back_to_back: got data=%b valid=%b ovr=%b want 0101 1 0", data_out, out_valid, overrun);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0 || data_out !== 4'b0101) begin
      n_err++; $display("FAIL drain_hold: got valid=%b data=%b want 0 0101", out_valid, data_out);
    end
  endtask

  task automatic test_gaps_async_reset();
    int gaps [3];
    gaps[0] = 0; gaps[1] = 3; gaps[2] = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, (i % 2 == 0), 1'b1, 1'b0, 1'b0);
      if (i < 3) for (int g = 0; g < gaps[i]; g++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    n_cmp++;
    if (data_out !== 4'b1010 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL gap_word: got data=%b valid=%b want 1010 1", data_out, out_valid);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({data_out, out_valid, overrun, bit_cnt, busy} !== '0) begin
      n_err++; $display("FAIL async_reset: got %b want %b", {data_out, out_valid, overrun, bit_cnt, busy}, {VW{1'b0}});
    end
    @(negedge clk);
    rst = 1'b0;
    send_word(4'b1001, 1'b0, 1'b0);
    n_cmp++;
    if (data_out !== 4'b1001 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      n_err++; $display("FAIL post_reset_word: got data=%b valid=%b ovr=%b want 1001 1 0", data_out, out_valid, overrun);
    end
  endtask

  task automatic test_random();
    logic v, s, d, c, r;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 6);
      s = $urandom_range(0, 1);
      d = $urandom_range(0, 1);
      c = ($urandom_range(0, 29) == 0);
      r = $urandom_range(0, 1);
      cyc(v, s, d, c, r);
      n_cmp++;
      if ({data_out, out_valid, overrun, bit_cnt, busy} !== exp_vec()) begin
        n_err++; $display("FAIL random[%0d]: got %b want %b", i, {data_out, out_valid, overrun, bit_cnt, busy}, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_clr();
    test_back_to_back();
    test_gaps_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
